// File: rtl/hwpe_stream_tcdm_rr_arbiter_if.sv
// Bus bundle for the TCDM round-robin arbiter: NB_IN requester ports on one
// side, a single shared TCDM master port on the other.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding environment (requesters plus memory).
interface hwpe_stream_tcdm_rr_arbiter_if #(
  parameter int NB_IN      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // requester side
  logic [NB_IN-1:0]            in_req_i;
  logic [NB_IN-1:0]            in_gnt_o;
  logic [NB_IN*ADDR_WIDTH-1:0] in_add_i;
  logic [NB_IN-1:0]            in_wen_i;
  logic [NB_IN*BE_WIDTH-1:0]   in_be_i;
  logic [NB_IN*DATA_WIDTH-1:0] in_data_i;
  logic [NB_IN*DATA_WIDTH-1:0] in_r_data_o;
  logic [NB_IN-1:0]            in_r_valid_o;

  // shared memory side
  logic                        out_req_o;
  logic                        out_gnt_i;
  logic [ADDR_WIDTH-1:0]       out_add_o;
  logic                        out_wen_o;
  logic [BE_WIDTH-1:0]         out_be_o;
  logic [DATA_WIDTH-1:0]       out_data_o;
  logic [DATA_WIDTH-1:0]       out_r_data_i;
  logic                        out_r_valid_i;

  modport slave (
    input  in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
    input  out_gnt_i, out_r_data_i, out_r_valid_i,
    output in_gnt_o, in_r_data_o, in_r_valid_o,
    output out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o
  );

  modport master (
    output in_req_i, in_add_i, in_wen_i, in_be_i, in_data_i,
    output out_gnt_i, out_r_data_i, out_r_valid_i,
    input  in_gnt_o, in_r_data_o, in_r_valid_o,
    input  out_req_o, out_add_o, out_wen_o, out_be_o, out_data_o
  );
endinterface

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master port between NB_IN requesters.
// Read responses are steered back through an in-order FIFO of requester IDs,
// so memory response latency may vary. The FIFO full flag is registered so
// there is no combinational path from out_r_valid_i to out_req_o.
// Optional: define HWPE_TCDM_ARB_STALL_CNT_EN to build the saturating
// contention counter on stall_cnt_o (tied to 0 otherwise).
module hwpe_stream_tcdm_rr_arbiter #(
  parameter int NB_IN           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  hwpe_stream_tcdm_rr_arbiter_if.slave bus,
  output logic                         busy_o,
  output logic [31:0]                  stall_cnt_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int ID_W     = $clog2(NB_IN);
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [ID_W-1:0]  id_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam id_t              LAST_ID  = id_t'(NB_IN - 1);
  localparam ptr_t             LAST_PTR = ptr_t'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  // (base + off) mod NB_IN for off in [0, NB_IN)
  function automatic id_t rr_idx(input id_t base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NB_IN) sum = sum - NB_IN;
    return id_t'(sum);
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  id_t              rr_reg;
  id_t              winner;
  ptr_t             wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             fifo_full_reg, fifo_empty_reg;
  id_t              id_mem [MAX_OUTSTANDING];
  id_t              head_id;
  logic             any_req, handshake, push, pop;
  logic [NB_IN-1:0] gnt_vec, rvalid_vec;

  logic [ADDR_WIDTH-1:0] add_arr  [NB_IN];
  logic [BE_WIDTH-1:0]   be_arr   [NB_IN];
  logic [DATA_WIDTH-1:0] data_arr [NB_IN];

  for (genvar gi = 0; gi < NB_IN; gi++) begin : g_unpack
    assign add_arr[gi]  = bus.in_add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_arr[gi]   = bus.in_be_i[gi*BE_WIDTH +: BE_WIDTH];
    assign data_arr[gi] = bus.in_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Winner: first requester at or after rr_reg, wrapping around.
  // Scanning offsets downwards lets the smallest offset overwrite last.
  always_comb begin
    winner = rr_reg;
    for (int off = NB_IN - 1; off >= 0; off--) begin
      if (bus.in_req_i[rr_idx(rr_reg, off)]) winner = rr_idx(rr_reg, off);
    end
  end

  assign any_req   = |bus.in_req_i;
  assign handshake = bus.out_req_o & bus.out_gnt_i;
  assign push      = handshake & bus.in_wen_i[winner];
  assign pop       = bus.out_r_valid_i & ~fifo_empty_reg;
  assign head_id   = id_mem[rd_ptr_reg];

  assign bus.out_req_o  = any_req & ~fifo_full_reg;
  assign bus.out_add_o  = add_arr[winner];
  assign bus.out_wen_o  = bus.in_wen_i[winner];
  assign bus.out_be_o   = be_arr[winner];
  assign bus.out_data_o = data_arr[winner];
  assign bus.in_r_data_o = {NB_IN{bus.out_r_data_i}};
  assign bus.in_gnt_o     = gnt_vec;
  assign bus.in_r_valid_o = rvalid_vec;
  assign busy_o           = any_req | ~fifo_empty_reg;

  // One-hot grant to the winner and one-hot response to the FIFO head.
  always_comb begin
    gnt_vec             = '0;
    rvalid_vec          = '0;
    gnt_vec[winner]     = handshake;
    rvalid_vec[head_id] = pop;
  end

  // FIFO occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_next = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  // Arbitration pointer and FIFO control; clear overrides any handshake update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_reg         <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      fifo_full_reg  <= 1'b0;
      fifo_empty_reg <= 1'b1;
    end else if (clear_i) begin
      rr_reg         <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      fifo_full_reg  <= 1'b0;
      fifo_empty_reg <= 1'b1;
    end else begin
      if (handshake) rr_reg <= (winner == LAST_ID) ? '0 : id_t'(winner + 1'b1);
      if (push)      wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)       rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      cnt_reg        <= cnt_next;
      fifo_full_reg  <= (cnt_next == FULL_CNT);
      fifo_empty_reg <= (cnt_next == '0);
    end
  end

  // ID storage; stale entries are harmless because the pointers gate access.
  always_ff @(posedge clk_i) begin
    if (push) id_mem[wr_ptr_reg] <= winner;
  end

`ifdef HWPE_TCDM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic        stalled;

  assign stalled     = |(bus.in_req_i & ~gnt_vec);
  assign stall_cnt_o = stall_cnt_reg;

  // Saturating count of cycles in which some requester waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_reg <= '0;
    end else if (clear_i) begin
      stall_cnt_reg <= '0;
    end else if (stalled && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// Self-checking bench for hwpe_stream_tcdm_rr_arbiter.
// Reference model: round-robin pointer as an int, outstanding reads as a queue
// of requester IDs and expected data; memory is an in-order response queue.
module tb_hwpe_stream_tcdm_rr_arbiter;
  localparam int NB = 4, MAXO = 2, AW = 32, DW = 32, BW = 4;
`ifdef HWPE_TCDM_ARB_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        busy;
  logic [31:0] stall_cnt;

  hwpe_stream_tcdm_rr_arbiter_if #(.NB_IN(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  hwpe_stream_tcdm_rr_arbiter #(
    .NB_IN(NB), .MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus),
    .busy_o(busy), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests_run = 0, tests_failed = 0, cyc = 0;
  // reference model state
  int          m_rr = 0;
  int          m_q[$];
  logic [31:0] m_dq[$];
  longint      m_stall = 0;
  // memory model
  int          pend_due[$];
  logic [31:0] pend_data[$];
  int          last_due = -1;
  int          lat = 1;
  // expectations for the current cycle
  int          e_w;
  logic        e_req, e_hs, e_busy, e_stalled;
  logic [NB-1:0] e_gnt, e_rv;
  logic [31:0] e_rdata;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic init_bus();
    bus.in_req_i = '0; bus.in_wen_i = '0; bus.in_add_i = '0;
    bus.in_be_i = '0; bus.in_data_i = '0; bus.out_gnt_i = 1'b0;
    bus.out_r_data_i = '0; bus.out_r_valid_i = 1'b0;
  endtask

  task automatic rand_port(input int k);
    bus.in_add_i[k*AW +: AW] = $urandom;
    bus.in_be_i[k*BW +: BW]  = 4'($urandom);
    bus.in_data_i[k*DW +: DW] = $urandom;
  endtask

  task automatic mem_drive(input bit spurious_ok);
    bus.out_r_valid_i = 1'b0;
    bus.out_r_data_i  = $urandom;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.out_r_valid_i = 1'b1;
      bus.out_r_data_i  = pend_data.pop_front();
      void'(pend_due.pop_front());
    end else if (spurious_ok && pend_due.size() == 0 && m_q.size() == 0 &&
                 $urandom_range(0, 3) == 0) begin
      bus.out_r_valid_i = 1'b1;
    end
  endtask

  // Expected outputs from the model state and the currently driven inputs.
  task automatic calc_expect();
    e_w = -1;
    for (int off = 0; off < NB; off++) begin
      int k;
      k = (m_rr + off) % NB;
      if (e_w < 0 && bus.in_req_i[k]) e_w = k;
    end
    e_req = (e_w >= 0) && (m_q.size() < MAXO);
    e_hs  = e_req && bus.out_gnt_i;
    e_gnt = '0;
    if (e_hs) e_gnt[e_w] = 1'b1;
    e_rv    = '0;
    e_rdata = bus.out_r_data_i;
    if (bus.out_r_valid_i && m_q.size() > 0) begin
      e_rv[m_q[0]] = 1'b1;
      e_rdata      = m_dq[0];
    end
    e_busy    = (e_w >= 0) || (m_q.size() > 0);
    e_stalled = |(bus.in_req_i & ~e_gnt);
  endtask

  task automatic cycle_begin(input bit spurious_ok);
    mem_drive(spurious_ok);
    #2;
    calc_expect();
  endtask

  // Advance the model and the memory across one clock edge.
  task automatic tick();
    logic [31:0] a;
    int due;
    a = (e_w >= 0) ? bus.in_add_i[e_w*AW +: AW] : 32'h0;
    if (clear) begin
      m_q.delete(); m_dq.delete(); m_rr = 0; m_stall = 0;
    end else begin
      if (e_rv != '0) begin void'(m_q.pop_front()); void'(m_dq.pop_front()); end
      if (e_hs) begin
        m_rr = (e_w + 1) % NB;
        if (bus.in_wen_i[e_w]) begin m_q.push_back(e_w); m_dq.push_back(mem_fn(a)); end
      end
      if (STALL_EN && e_stalled && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
    if (e_hs && bus.in_wen_i[e_w]) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      pend_due.push_back(due); pend_data.push_back(mem_fn(a)); last_due = due;
    end
    if (e_hs) rand_port(e_w);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    init_bus();
    rst_n = 1'b0;
    #12;
    tests_run++; if (bus.out_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_out_req got=%b exp=0", bus.out_req_o); end
    tests_run++; if (bus.in_gnt_o !== '0) begin tests_failed++; $display("FAIL reset_gnt got=%b exp=0", bus.in_gnt_o); end
    tests_run++; if (bus.in_r_valid_o !== '0) begin tests_failed++; $display("FAIL reset_rvalid got=%b exp=0", bus.in_r_valid_o); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    m_rr = 0; m_q.delete(); m_dq.delete(); m_stall = 0;
  endtask

  task automatic test_round_robin();
    logic [NB-1:0] exp_g, exp_r;
    int p;
    lat = 1;
    for (int k = 0; k < NB; k++) rand_port(k);
    bus.in_req_i = '1; bus.in_wen_i = '1; bus.out_gnt_i = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 12) bus.in_req_i = '0;
      cycle_begin(1'b0);
      exp_g = '0; if (i < 12) exp_g[i % 4] = 1'b1;
      exp_r = '0; if (i >= 1 && i <= 12) exp_r[(i - 1) % 4] = 1'b1;
      tests_run++; if (bus.in_gnt_o !== exp_g) begin tests_failed++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", cyc, bus.in_gnt_o, exp_g); end
      tests_run++; if (bus.in_r_valid_o !== exp_r) begin tests_failed++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", cyc, bus.in_r_valid_o, exp_r); end
      if (exp_r != '0) begin
        p = (i - 1) % 4;
        tests_run++; if (bus.in_r_data_o[p*DW +: DW] !== e_rdata) begin tests_failed++; $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", cyc, bus.in_r_data_o[p*DW +: DW], e_rdata); end
      end
      tick();
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rr_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_rr_start();
    int seq [3] = '{3, 1, 3};
    logic [NB-1:0] exp_g;
    bus.in_wen_i = '0; bus.in_req_i = 4'b0010; bus.out_gnt_i = 1'b1;
    cycle_begin(1'b0);
    tests_run++; if (bus.in_gnt_o !== 4'b0010) begin tests_failed++; $display("FAIL single_req_gnt cyc=%0d got=%b exp=0010", cyc, bus.in_gnt_o); end
    tick();
    bus.in_req_i = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle_begin(1'b0);
      exp_g = '0; exp_g[seq[i]] = 1'b1;
      tests_run++; if (bus.in_gnt_o !== exp_g) begin tests_failed++; $display("FAIL rr_from2_gnt step=%0d got=%b exp=%b", i, bus.in_gnt_o, exp_g); end
      tick();
    end
    bus.in_req_i = '0;
    cycle_begin(1'b0); tick();
  endtask

  task automatic test_backpressure();
    int g_order[$], r_order[$];
    bit ok;
    lat = 3;
    bus.in_req_i = '1; bus.in_wen_i = '1; bus.out_gnt_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 14) bus.in_req_i = '0;
      if (i >= 14 && pend_due.size() == 0 && m_q.size() == 0) break;
      cycle_begin(1'b0);
      tests_run++; if (bus.out_req_o !== e_req) begin tests_failed++; $display("FAIL bp_out_req cyc=%0d got=%b exp=%b", cyc, bus.out_req_o, e_req); end
      if (i == 2) begin
        tests_run++; if (bus.out_req_o !== 1'b0) begin tests_failed++; $display("FAIL bp_full_stop got=%b exp=0", bus.out_req_o); end
      end
      tests_run++; if (bus.in_gnt_o !== e_gnt) begin tests_failed++; $display("FAIL bp_gnt cyc=%0d got=%b exp=%b", cyc, bus.in_gnt_o, e_gnt); end
      tests_run++; if (bus.in_r_valid_o !== e_rv) begin tests_failed++; $display("FAIL bp_rvalid cyc=%0d got=%b exp=%b", cyc, bus.in_r_valid_o, e_rv); end
      if (e_hs) g_order.push_back(e_w);
      for (int k = 0; k < NB; k++) begin
        if (bus.in_r_valid_o[k] === 1'b1) begin
          r_order.push_back(k);
          tests_run++; if (bus.in_r_data_o[k*DW +: DW] !== e_rdata) begin tests_failed++; $display("FAIL bp_rdata cyc=%0d got=%h exp=%h", cyc, bus.in_r_data_o[k*DW +: DW], e_rdata); end
        end
      end
      tick();
    end
    ok = (g_order.size() == r_order.size()) && (g_order.size() > 0);
    if (ok) for (int k = 0; k < g_order.size(); k++) if (g_order[k] != r_order[k]) ok = 1'b0;
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_resp_order got=%0d responses exp=%0d in grant order", r_order.size(), g_order.size()); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_write_only();
    bus.in_req_i = 4'b0100; bus.in_wen_i = '0; bus.out_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle_begin(1'b0);
      tests_run++; if (bus.in_gnt_o !== 4'b0100) begin tests_failed++; $display("FAIL wr_gnt cyc=%0d got=%b exp=0100", cyc, bus.in_gnt_o); end
      tests_run++; if (bus.in_r_valid_o !== '0) begin tests_failed++; $display("FAIL wr_rvalid cyc=%0d got=%b exp=0", cyc, bus.in_r_valid_o); end
      tests_run++; if (bus.out_wen_o !== 1'b0) begin tests_failed++; $display("FAIL wr_wen cyc=%0d got=%b exp=0", cyc, bus.out_wen_o); end
      tests_run++; if (bus.out_add_o !== bus.in_add_i[2*AW +: AW]) begin tests_failed++; $display("FAIL wr_add cyc=%0d got=%h exp=%h", cyc, bus.out_add_o, bus.in_add_i[2*AW +: AW]); end
      tick();
    end
    bus.in_req_i = '0;
    cycle_begin(1'b0);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_fifo_untouched busy got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_clear();
    lat = 3;
    bus.in_req_i = '1; bus.in_wen_i = '1; bus.out_gnt_i = 1'b1;
    cycle_begin(1'b0); tick();
    cycle_begin(1'b0); tick();
    bus.in_req_i = '0; clear = 1'b1;
    cycle_begin(1'b0);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL clr_busy_before got=%b exp=1", busy); end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle_begin(1'b0);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL clr_busy_after cyc=%0d got=%b exp=0", cyc, busy); end
      tests_run++; if (bus.in_r_valid_o !== '0) begin tests_failed++; $display("FAIL clr_late_rvalid cyc=%0d got=%b exp=0", cyc, bus.in_r_valid_o); end
      tick();
    end
    // clear together with a handshake: grant is shown, pointer still resets
    bus.in_req_i = 4'b0101; bus.in_wen_i = 4'b0101; clear = 1'b1;
    cycle_begin(1'b0);
    tests_run++; if (bus.in_gnt_o !== 4'b0001) begin tests_failed++; $display("FAIL clr_comb_gnt got=%b exp=0001", bus.in_gnt_o); end
    tick();
    clear = 1'b0; bus.in_wen_i = '0;
    cycle_begin(1'b0);
    tests_run++; if (bus.in_gnt_o !== 4'b0001) begin tests_failed++; $display("FAIL clr_rr_zero got=%b exp=0001", bus.in_gnt_o); end
    tick();
    bus.in_req_i = '0;
    for (int i = 0; i < 6; i++) begin
      cycle_begin(1'b0);
      tests_run++; if (bus.in_r_valid_o !== e_rv) begin tests_failed++; $display("FAIL clr_discard cyc=%0d got=%b exp=%b", cyc, bus.in_r_valid_o, e_rv); end
      tick();
    end
    tests_run++; if (busy !== 1'b0 || pend_due.size() != 0) begin tests_failed++; $display("FAIL clr_end busy got=%b exp=0", busy); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_c;
    bus.in_req_i = '0; clear = 1'b1;
    cycle_begin(1'b0); tick();
    clear = 1'b0;
    bus.in_req_i = 4'b0111; bus.in_wen_i = '0; bus.out_gnt_i = 1'b1;
    for (int i = 0; i < 10; i++) begin cycle_begin(1'b0); tick(); end
    bus.in_req_i = '0;
    exp_c = STALL_EN ? 32'd10 : 32'd0;
    for (int i = 0; i < 2; i++) begin
      cycle_begin(1'b0);
      tests_run++; if (stall_cnt !== exp_c) begin tests_failed++; $display("FAIL stall_cnt step=%0d got=%0d exp=%0d", i, stall_cnt, exp_c); end
      tests_run++; if (stall_cnt !== 32'(m_stall)) begin tests_failed++; $display("FAIL stall_model step=%0d got=%0d exp=%0d", i, stall_cnt, m_stall); end
      tick();
    end
  endtask

  task automatic test_random();
    bus.in_req_i = '0;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NB; k++) begin
        if (!bus.in_req_i[k] && $urandom_range(0, 1) == 1) begin
          bus.in_req_i[k] = 1'b1;
          bus.in_wen_i[k] = 1'($urandom_range(0, 1));
          rand_port(k);
        end
      end
      bus.out_gnt_i = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      cycle_begin(1'b1);
      tests_run++; if (bus.out_req_o !== e_req) begin tests_failed++; $display("FAIL rnd_out_req cyc=%0d got=%b exp=%b", cyc, bus.out_req_o, e_req); end
      tests_run++; if (bus.in_gnt_o !== e_gnt) begin tests_failed++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, bus.in_gnt_o, e_gnt); end
      tests_run++; if (bus.in_r_valid_o !== e_rv) begin tests_failed++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.in_r_valid_o, e_rv); end
      tests_run++; if (busy !== e_busy) begin tests_failed++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      tests_run++; if (stall_cnt !== 32'(m_stall)) begin tests_failed++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall); end
      if (e_w >= 0) begin
        tests_run++; if (bus.out_add_o !== bus.in_add_i[e_w*AW +: AW] || bus.out_wen_o !== bus.in_wen_i[e_w])
          begin tests_failed++; $display("FAIL rnd_mux cyc=%0d got=%h/%b exp=%h/%b", cyc, bus.out_add_o, bus.out_wen_o, bus.in_add_i[e_w*AW +: AW], bus.in_wen_i[e_w]); end
      end
      if (e_rv != '0) begin
        tests_run++; if (bus.in_r_data_o[m_q[0]*DW +: DW] !== e_rdata) begin tests_failed++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.in_r_data_o[m_q[0]*DW +: DW], e_rdata); end
      end
      tick();
      if (e_hs) bus.in_req_i[e_w] = 1'b0;
    end
    bus.in_req_i = '0; bus.out_gnt_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pend_due.size() == 0 && m_q.size() == 0) break;
      cycle_begin(1'b0);
      tests_run++; if (bus.in_r_valid_o !== e_rv) begin tests_failed++; $display("FAIL rnd_drain_rvalid cyc=%0d got=%b exp=%b", cyc, bus.in_r_valid_o, e_rv); end
      tick();
    end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rnd_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset();
    lat = 4;
    bus.in_req_i = 4'b0010; bus.in_wen_i = 4'b0010; bus.out_gnt_i = 1'b1;
    cycle_begin(1'b0); tick();
    bus.in_req_i = '0; bus.out_r_valid_i = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL arst_busy_before got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL arst_busy got=%b exp=0", busy); end
    bus.out_r_valid_i = 1'b1;
    #1;
    tests_run++; if (bus.in_r_valid_o !== '0) begin tests_failed++; $display("FAIL arst_rvalid got=%b exp=0", bus.in_r_valid_o); end
    @(negedge clk); rst_n = 1'b1; bus.out_r_valid_i = 1'b0;
    m_q.delete(); m_dq.delete(); pend_due.delete(); pend_data.delete(); m_rr = 0; m_stall = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_rr_start();
    test_backpressure();
    test_write_only();
    test_clear();
    test_stall();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hwpe_stream_tcdm_rr_arbiter.md
Name: hwpe_stream_tcdm_rr_arbiter

Overview:
- Shares one TCDM master port between NB_IN TCDM requesters, such as HWPE streamers or sources/sinks.
- Arbitration is round-robin, one grant per cycle.
- Read responses are routed back to the originating requester through an in-order ID FIFO, so memory-side response latency may vary.
- Sits between the HWPE engine's TCDM masters and the cluster interconnect port.

Parameters:
NB_IN, 4, number of requester ports (>=2).
MAX_OUTSTANDING, 2, depth of the read-ID FIFO (>=1); also the maximum number of granted reads awaiting r_valid.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width; byte enable width is DATA_WIDTH/8.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
in_req_i  in  NB_IN  per-requester request
in_gnt_o  out  NB_IN  per-requester grant
in_add_i  in  NB_IN*ADDR_WIDTH  packed addresses, port k at slice k
in_wen_i  in  NB_IN  1 = read, 0 = write
in_be_i  in  NB_IN*DATA_WIDTH/8  packed byte enables
in_data_i  in  NB_IN*DATA_WIDTH  packed write data
in_r_data_o  out  NB_IN*DATA_WIDTH  read data, broadcast to all slices
in_r_valid_o  out  NB_IN  one-hot read-valid
out_req_o  out  1  shared-port request
out_gnt_i  in  1  shared-port grant
out_add_o  out  ADDR_WIDTH  muxed address
out_wen_o  out  1  muxed wen
out_be_o  out  DATA_WIDTH/8  muxed byte enable
out_data_o  out  DATA_WIDTH  muxed write data
out_r_data_i  in  DATA_WIDTH  read data
out_r_valid_i  in  1  read-valid
busy_o  out  1  requests pending or reads outstanding
stall_cnt_o  out  32  contention counter (see Optional Feature)

Behaviour:
- Reset (rst_ni=0, async): rr_q=0, ID FIFO empty, stall count 0. All outputs derived from state are therefore 0 (in_gnt_o, in_r_valid_o, out_req_o, busy_o, stall_cnt_o).
- Winner selection (combinational): w = first k with in_req_i[k]=1, searching k = rr_q, rr_q+1, ... modulo NB_IN.
- out_req_o = (|in_req_i) & ~fifo_full_q.
  - The full flag is registered, so there is no combinational path from out_r_valid_i to out_req_o.
- out_add_o, out_wen_o, out_be_o and out_data_o are taken from slice w.
  - When no requester is active they output slice rr_q; these values are don't-care.
- in_gnt_o[w] = out_req_o & out_gnt_i; all other grant bits are 0.
- Handshake (out_req_o & out_gnt_i):
  - rr_q <= (w+1) mod NB_IN.
  - If in_wen_i[w]=1, push w into the ID FIFO.
  - Writes are not tracked and produce no response.
- Response: when out_r_valid_i=1, pop the FIFO head h and drive in_r_valid_o = one-hot(h), valid in the same cycle (combinational).
  - in_r_data_o replicates out_r_data_i on every slice.
- Simultaneous push and pop in one cycle: both happen; occupancy is unchanged; the pop is taken from the old head.
- FIFO full: no new requests are issued; the in-flight handshake is unaffected.
  - With MAX_OUTSTANDING=1, zero-latency memories sustain one read every 2 cycles.
  - With MAX_OUTSTANDING>=2, zero-latency memories sustain full throughput.
- out_r_valid_i while the FIFO is empty: no in_r_valid_o bit is asserted and the response is discarded.
- Requesters must hold req, add, wen, be and data stable until gnt; the arbiter does not register them.
- Single requester: it is granted on every cycle in which out_gnt_i=1, regardless of rr_q.
- clear_i=1 (synchronous, overrides a same-cycle handshake update):
  - rr_q=0, FIFO emptied, stall count 0.
  - Responses for reads granted before the clear are discarded.
  - Combinational grant still follows the current inputs in that cycle.
- busy_o = (|in_req_i) | ~fifo_empty_q.

Optional Feature:
- Macro HWPE_TCDM_ARB_STALL_CNT_EN, when defined:
  - A 32-bit counter increments each cycle in which at least one k has in_req_i[k]=1 & in_gnt_o[k]=0.
  - The counter saturates at 2^32-1 and is cleared by rst_ni and clear_i.
  - stall_cnt_o outputs the counter.
- Macro undefined: no counter flops; stall_cnt_o is tied to 0.

Test Plan:
1. All 4 ports request reads continuously, out_gnt_i=1, memory has 1-cycle latency, MAX_OUTSTANDING=2 -> grants in order 0,1,2,3,0... with one grant per cycle; in_r_valid_o follows the grant one cycle later with matching port and data.
2. Ports 1 and 3 request, rr_q=2 -> port 3 granted first, then port 1, then port 3.
3. Variable latency: memory returns reads 3 cycles after grant, MAX_OUTSTANDING=2 -> out_req_o drops after 2 outstanding reads; responses are delivered in grant order; no response is lost.
4. Write-only traffic from port 2 -> grant every cycle, FIFO never pushed, in_r_valid_o stays 0.
5. clear_i asserted with 2 reads outstanding -> FIFO empty, rr_q=0; the 2 late out_r_valid_i pulses produce no in_r_valid_o.
6. With HWPE_TCDM_ARB_STALL_CNT_EN, 3 ports requesting for 10 cycles with out_gnt_i=1 -> stall_cnt_o=10. Without the macro -> stall_cnt_o=0.
